// File: rtl/tx_stream_arbiter.sv
// tx_stream_arbiter: round-robin arbiter that merges N_REQ stb/ack producer channels into one
// registered stb/ack output stream through a single-entry buffer.
// Optional packet lock (macro TX_ARB_PACKET_LOCK_EN): keeps the grant on one requester until a
// word whose low byte equals EOM is captured, with a sticky timeout exception.

module tx_stream_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter logic [7:0]  EOM          = 8'h0A,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        exception,
    input  logic [N_REQ*DATA_WIDTH-1:0] input_in,
    input  logic [N_REQ-1:0]            input_in_stb,
    output logic [N_REQ-1:0]            input_in_ack,
    output logic [DATA_WIDTH-1:0]       output_out,
    output logic                        output_out_stb,
    input  logic                        output_out_ack,
    output logic [N_REQ-1:0]            grant
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [N_REQ-1:0]      ack_q, ack_d;
    logic [N_REQ-1:0]      mask_q, mask_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  stb_q, stb_d;
    logic [N_REQ-1:0]      grant_q, grant_d;

    logic [N_REQ-1:0]      cand;
    logic                  found;
    logic [IDX_W-1:0]      pick;
    logic [DATA_WIDTH-1:0] pick_word;
    logic                  go;

`ifdef TX_ARB_PACKET_LOCK_EN
    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic             lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exc_q, exc_d;
    logic             timeout;
`endif

    // Rotating-priority search over eligible requesters, starting just after the last grant.
    always_comb begin
        cand = input_in_stb & ~mask_q;
`ifdef TX_ARB_PACKET_LOCK_EN
        // While locked only the owner of the packet may be granted.
        if (lock_q) begin
            cand = cand & (ONE << last_q);
        end
`endif
        found = 1'b0;
        pick  = last_q;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            int j;
            j = (int'(last_q) + k) % int'(N_REQ);
            if (!found && cand[j]) begin
                found = 1'b1;
                pick  = IDX_W'(j);
            end
        end
        pick_word = input_in[pick*DATA_WIDTH +: DATA_WIDTH];
    end

    // Next-state logic for the IDLE/SEND buffer and the optional lock.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        ack_d   = '0;
        // A requester acked last cycle may still show its old stb; hide it for one cycle.
        mask_d  = ack_q;
        data_d  = data_q;
        stb_d   = stb_q;
        grant_d = grant_q;
        go      = 1'b0;
`ifdef TX_ARB_PACKET_LOCK_EN
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        exc_d   = exc_q;
        timeout = lock_q && (cnt_q == CNT_W'(LOCK_TIMEOUT));
`endif
        unique case (state_q)
            StIdle: begin
                go = found;
`ifdef TX_ARB_PACKET_LOCK_EN
                if (timeout) begin
                    // Abandon the stalled packet; round-robin resumes after its owner.
                    go     = 1'b0;
                    lock_d = 1'b0;
                    exc_d  = 1'b1;
                    cnt_d  = '0;
                end else if (lock_q && !input_in_stb[last_q]) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
                if (go) begin
                    data_d  = pick_word;
                    ack_d   = ONE << pick;
                    grant_d = ONE << pick;
                    stb_d   = 1'b1;
                    last_d  = pick;
                    state_d = StSend;
`ifdef TX_ARB_PACKET_LOCK_EN
                    cnt_d   = '0;
                    lock_d  = (pick_word[7:0] != EOM);
`endif
                end
            end
            StSend: begin
                if (output_out_ack) begin
                    stb_d   = 1'b0;
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset discards any held word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            last_q  <= IDX_W'(N_REQ - 1);
            ack_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            stb_q   <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
            grant_q <= grant_d;
        end
    end

`ifdef TX_ARB_PACKET_LOCK_EN
    // Lock owner flag, idle counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q <= 1'b0;
            cnt_q  <= '0;
            exc_q  <= 1'b0;
        end else begin
            lock_q <= lock_d;
            cnt_q  <= cnt_d;
            exc_q  <= exc_d;
        end
    end

    assign exception = exc_q;
`else
    assign exception = 1'b0;
`endif

    assign input_in_ack   = ack_q;
    assign output_out     = data_q;
    assign output_out_stb = stb_q;
    assign grant          = grant_q;

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Directed, table-driven bench for tx_stream_arbiter (4 requesters, 32-bit words).

module tb_tx_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    // Every table word ends in the EOM byte so the table holds with or without packet lock.
    localparam logic [31:0] W0 = 32'hA000_000A;
    localparam logic [31:0] W1 = 32'hA100_000A;
    localparam logic [31:0] W2 = 32'h4100_000A;
    localparam logic [31:0] W3 = 32'hA300_000A;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            exception;
    logic [N*DW-1:0] input_in;
    logic [N-1:0]    input_in_stb;
    logic [N-1:0]    input_in_ack;
    logic [DW-1:0]   output_out;
    logic            output_out_stb;
    logic            output_out_ack;
    logic [N-1:0]    grant;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        logic [3:0]  stb;
        logic        oack;
        logic [3:0]  ack;
        logic        ostb;
        logic [31:0] out;
        logic [3:0]  grant;
    } vec_t;

    vec_t tbl[17];

    tx_stream_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .exception      (exception),
        .input_in       (input_in),
        .input_in_stb   (input_in_stb),
        .input_in_ack   (input_in_ack),
        .output_out     (output_out),
        .output_out_stb (output_out_stb),
        .output_out_ack (output_out_ack),
        .grant          (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  exp_ack;
        logic [31:0] got_w[4];
        logic [31:0] exp_w[4];
        int          got;
        int          idx;
        int          cyc;
        logic        seen_ack0;

        // stb, oack | ack, ostb, out, grant
        tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0, 4'b0000};
        tbl[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, W2,    4'b0100};
        tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, W2,    4'b0000};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, W3,    4'b1000};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, W3,    4'b1000};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, W3,    4'b1000};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, W3,    4'b0000};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, W0,    4'b0001};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, W0,    4'b0000};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, W1,    4'b0010};
        tbl[10] = '{4'b1111, 1'b1, 4'b0000, 1'b0, W1,    4'b0000};
        tbl[11] = '{4'b0010, 1'b1, 4'b0000, 1'b0, W1,    4'b0000};
        tbl[12] = '{4'b0010, 1'b1, 4'b0010, 1'b1, W1,    4'b0010};
        tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1, W1,    4'b0010};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, W1,    4'b0000};
        tbl[15] = '{4'b0001, 1'b1, 4'b0001, 1'b1, W0,    4'b0001};
        tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, W0,    4'b0000};

        input_in       = {W3, W2, W1, W0};
        input_in_stb   = '0;
        output_out_ack = 1'b0;

        // Reset values.
        #12;
        check("reset ack", 32'(input_in_ack), 32'h0);
        check("reset ostb", 32'(output_out_stb), 32'h0);
        check("reset out", output_out, 32'h0);
        check("reset grant", 32'(grant), 32'h0);
        check("reset exception", 32'(exception), 32'h0);
        rst = 1'b1;
        tick();

        // Table: single requester, stale-stb mask, rotation, short backpressure.
        for (int i = 0; i < 17; i++) begin
            input_in_stb   = tbl[i].stb;
            output_out_ack = tbl[i].oack;
            tick();
            check($sformatf("v%0d ack", i), 32'(input_in_ack), 32'(tbl[i].ack));
            check($sformatf("v%0d ostb", i), 32'(output_out_stb), 32'(tbl[i].ostb));
            check($sformatf("v%0d out", i), output_out, tbl[i].out);
            check($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].grant));
        end

        // Backpressure: word held for 10 cycles, no further acks, exactly one delivery.
        input_in_stb   = 4'b0100;
        output_out_ack = 1'b0;
        tick();
        check("bp capture ack", 32'(input_in_ack), 32'h4);
        check("bp capture out", output_out, W2);
        input_in_stb = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp hold%0d ack", i), 32'(input_in_ack), 32'h0);
            check($sformatf("bp hold%0d ostb", i), 32'(output_out_stb), 32'h1);
            check($sformatf("bp hold%0d out", i), output_out, W2);
        end
        input_in_stb   = 4'b0000;
        output_out_ack = 1'b1;
        tick();
        check("bp release ostb", 32'(output_out_stb), 32'h0);
        output_out_ack = 1'b0;
        tick();
        check("bp single ostb", 32'(output_out_stb), 32'h0);
        check("bp single ack", 32'(input_in_ack), 32'h0);

        // Reset mid-SEND: outputs clear without a clock edge.
        input_in_stb = 4'b1000;
        tick();
        check("rs send ostb", 32'(output_out_stb), 32'h1);
        check("rs send out", output_out, W3);
        #2 rst = 1'b0;
        #1;
        check("rs async ostb", 32'(output_out_stb), 32'h0);
        check("rs async out", output_out, 32'h0);
        check("rs async grant", 32'(grant), 32'h0);
        check("rs async ack", 32'(input_in_ack), 32'h0);
        input_in_stb   = 4'b1111;
        output_out_ack = 1'b1;
        #2 rst = 1'b1;

        // All contending after reset: grants 0,1,2,3,0 every other cycle, one-cycle acks.
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp_ack = (c % 2 == 1) ? (4'b0001 << (((c - 1) / 2) % 4)) : 4'b0000;
            check($sformatf("rr c%0d ack", c), 32'(input_in_ack), 32'(exp_ack));
            check($sformatf("rr c%0d grant", c), 32'(grant), 32'(exp_ack));
        end
        input_in_stb = '0;

`ifdef TX_ARB_PACKET_LOCK_EN
        // Packet lock: req1 message stays contiguous while req0 waits.
        rst = 1'b0;
        #2 rst = 1'b1;
        exp_w[0] = 32'h48;
        exp_w[1] = 32'h49;
        exp_w[2] = 32'h0A;
        exp_w[3] = 32'h30;
        input_in[0*DW +: DW] = 32'h30;
        input_in[1*DW +: DW] = 32'h48;
        input_in_stb   = 4'b0010;
        output_out_ack = 1'b1;
        got = 0;
        idx = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            tick();
            if (output_out_stb) begin
                got_w[got] = output_out;
                got++;
            end
            if (input_in_ack[1]) idx++;
            input_in_stb[1] = (idx < 3);
            if (idx < 3) input_in[1*DW +: DW] = exp_w[idx];
            input_in_stb[0] = 1'b1;
        end
        check("lock word count", 32'(got), 32'd4);
        for (int i = 0; i < got; i++) begin
            check($sformatf("lock word%0d", i), got_w[i], exp_w[i]);
        end
        input_in_stb = '0;

        // Lock timeout: req1 stalls mid-message, req0 granted only after the exception.
        rst = 1'b0;
        #2 rst = 1'b1;
        input_in[1*DW +: DW] = 32'h48;
        input_in_stb = 4'b0010;
        tick();
        input_in_stb = 4'b0001;
        cyc       = 0;
        seen_ack0 = 1'b0;
        while (!exception && cyc < 1200) begin
            tick();
            cyc++;
            if (input_in_ack[0]) seen_ack0 = 1'b1;
        end
        check("timeout exception", 32'(exception), 32'h1);
        check("timeout not early", 32'(cyc >= 1024), 32'h1);
        check("timeout no early ack0", 32'(seen_ack0), 32'h0);
        idx = 0;
        for (int c = 0; c < 5 && idx == 0; c++) begin
            tick();
            if (input_in_ack[0]) idx = 1;
        end
        check("timeout req0 granted", 32'(idx), 32'h1);
        check("timeout sticky", 32'(exception), 32'h1);
        input_in_stb = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/tx_stream_arbiter.md
# tx_stream_arbiter

Round-robin arbiter sharing one 32-bit stb/ack output stream (typically `output_rs232_tx`) among N_REQ producer threads in `user_design`. Each requester presents words on its own stb/ack channel. The arbiter buffers one word at a time and forwards it to the single downstream consumer. Optionally, it holds the grant for a whole message until an end-of-message byte.

## Interface
- `N_REQ`, default 4: number of requester channels (legal range 2..8).
- `DATA_WIDTH`, default 32: word width.
- `EOM`, default 8'h0A: end-of-message value, compared against `data[7:0]`. Used only with lock.
- `LOCK_TIMEOUT`, default 1024: idle cycles before a held lock is forcibly released. Used only with lock.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `exception` out 1: sticky lock-timeout flag.
- `input_in` in N_REQ*DATA_WIDTH: requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `input_in_stb` in N_REQ: per-requester valid.
- `input_in_ack` out N_REQ: per-requester accept, one-hot pulse.
- `output_out` out DATA_WIDTH: forwarded word, registered.
- `output_out_stb` out 1: output valid.
- `output_out_ack` in 1: downstream accept.
- `grant` out N_REQ: one-hot index of the requester whose word is currently held (debug).

## Operation
- **Transfer rule:** a word moves on any channel in a cycle where stb and ack are both high.
- **IDLE state:**
  - Candidates are requesters with stb high, excluding any requester acked in the previous cycle (stale-stb mask).
  - Pick the first candidate scanning from `(last+1) mod N_REQ` upward with wrap.
  - On a pick: at the clock edge, capture its word into `output_out`, set `input_in_ack[i]`=1, `output_out_stb`=1, `grant`=onehot(i), `last`=i, and go to SEND.
- **SEND state:**
  - `input_in_ack` returns to 0 after its single cycle.
  - Hold `output_out` and `output_out_stb` until `output_out_ack`=1.
  - At that edge, clear `output_out_stb` and `grant`, then return to IDLE.
- **Throughput:** at most one word per requester every 3 cycles. No new word is accepted while SEND is occupied; the buffer is one entry.
- **Fairness:** every requester is served within N_REQ grants of raising stb.
- **Ignored input:** a requester dropping stb before being acked is ignored; no ack is issued.
- **Simultaneous requests:** resolved purely by the rotating priority.
- **Reset values:** `last`=N_REQ-1 (so requester 0 wins first); `input_in_ack`=0; `output_out`=0; `output_out_stb`=0; `grant`=0; `exception`=0; state IDLE; lock cleared.
- **Reset mid-SEND:** the held word is discarded and all outputs clear asynchronously.

## Timing
- **Latency:** requester stb sampled in IDLE at cycle t → `input_in_ack` and `output_out_stb` high in cycle t+1.
  - With `output_out_ack` already high in t+1, the word leaves at t+1 and the arbiter is back in IDLE at t+2.
- **Ack width:** `input_in_ack` is exactly one cycle wide and never asserted for two requesters at once.
- **Stale-stb mask:** applies for exactly the one IDLE cycle after the ack.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.

## Configuration
- **Macro:** `TX_ARB_PACKET_LOCK_EN`.
- **Defined:**
  - After granting requester i a word whose `data[7:0]` != EOM, lock to i. IDLE then considers only i, and the stale-stb mask still applies.
  - Lock releases when a word with `data[7:0]`==EOM is captured.
  - While locked in IDLE, a counter increments each cycle that i has stb low, and resets on a grant.
  - When the counter reaches LOCK_TIMEOUT, release the lock, set `exception`=1 (sticky until reset), and resume round-robin from i+1.
- **Undefined:** every word is arbitrated independently, with no counter and no lock register, and `exception` is tied to 0.

## Test plan
- **Single requester:** requester 2 sends 0x41; `output_out_ack` held high → `input_in_ack[2]` pulse at t+1, `output_out`=0x41 with stb at t+1, stb low at t+2.
- **All requesters contending:** all 4 stb high continuously after reset → grant order 0,1,2,3,0; each `input_in_ack` is one cycle wide.
- **Backpressure:** `output_out_ack` held low 10 cycles → `output_out_stb` and data stay stable, no further `input_in_ack`; one word delivered when ack rises.
- **Reset mid-SEND:** `rst` driven low while `output_out_stb`=1 → all outputs 0 immediately; after release, requester 0 wins first.
- **Lock (macro defined):** req1 sends 0x48,0x49,0x0A while req0 requests → output 0x48,0x49,0x0A contiguous, then req0 served.
- **Lock timeout (macro defined):** req1 sends 0x48 then stops, req0 requesting → after 1024 idle cycles `exception`=1 and req0 is granted.
